// File: rtl/sdram_host_arbiter.sv
// Shares one SDRAM controller host port between instruction fetch (port 0) and data (port 1).
// Level-held requests become the controller's RD/WR command; grants alternate on ties.
module sdram_host_arbiter #(
    parameter int ASIZE   = 23,
    parameter int DSIZE   = 16,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic               REF_CLK,
    input  logic               RESET_N,
    input  logic               P0_REQ,
    input  logic               P0_WR,
    input  logic [ASIZE-1:0]   P0_ADDR,
    input  logic [7:0]         P0_LEN,
    input  logic [DSIZE-1:0]   P0_WDATA,
    input  logic [DSIZE/8-1:0] P0_DM,
    output logic               P0_IN_REQ,
    output logic               P0_OUT_VALID,
    output logic [DSIZE-1:0]   P0_RDATA,
    output logic               P0_DONE,
    output logic               P0_ERR,
    input  logic               P1_REQ,
    input  logic               P1_WR,
    input  logic [ASIZE-1:0]   P1_ADDR,
    input  logic [7:0]         P1_LEN,
    input  logic [DSIZE-1:0]   P1_WDATA,
    input  logic [DSIZE/8-1:0] P1_DM,
    output logic               P1_IN_REQ,
    output logic               P1_OUT_VALID,
    output logic [DSIZE-1:0]   P1_RDATA,
    output logic               P1_DONE,
    output logic               P1_ERR,
    output logic [ASIZE-1:0]   C_ADDR,
    output logic [7:0]         C_LENGTH,
    output logic               C_RD,
    output logic               C_WR,
    output logic [DSIZE-1:0]   C_DATAIN,
    output logic [DSIZE/8-1:0] C_DM,
    input  logic               C_DONE,
    input  logic               C_IN_REQ,
    input  logic               C_OUT_VALID,
    input  logic [DSIZE-1:0]   C_DATAOUT
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    state_t             state_reg, state_next;
    logic               owner_reg;
    logic               last_reg;
    logic [ASIZE-1:0]   addr_reg;
    logic [7:0]         len_reg;
    logic               wr_reg;
    logic [3:0]         gap_cnt_reg;
    logic [11:0]        tmo_cnt_reg;
    logic [1:0]         done_reg, done_next;
    logic [1:0]         err_reg, err_next;

    logic [1:0]         req;
    logic [1:0]         wr_in;
    logic [ASIZE-1:0]   addr_in  [2];
    logic [7:0]         len_in   [2];
    logic [DSIZE-1:0]   wdata_in [2];
    logic [DSIZE/8-1:0] dm_in    [2];
    logic [1:0]         in_req_out;
    logic [1:0]         out_valid_out;

    logic grant_valid;
    logic grant_port;
    logic tmo_hit;
    logic busy;

    assign req         = {P1_REQ, P0_REQ};
    assign wr_in       = {P1_WR, P0_WR};
    assign addr_in[0]  = P0_ADDR;
    assign addr_in[1]  = P1_ADDR;
    assign len_in[0]   = P0_LEN;
    assign len_in[1]   = P1_LEN;
    assign wdata_in[0] = P0_WDATA;
    assign wdata_in[1] = P1_WDATA;
    assign dm_in[0]    = P0_DM;
    assign dm_in[1]    = P1_DM;

    // On a tie the port that did not win last time is granted.
    assign grant_valid = (state_reg == S_IDLE) && (req != 2'b00);
    assign grant_port  = (req == 2'b11) ? ~last_reg : req[1];
    assign tmo_hit     = (tmo_cnt_reg == 12'(TIMEOUT - 1));
    assign busy        = (state_reg == S_BUSY);

    always_ff @(posedge REF_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 2'b00;
        err_next   = 2'b00;
        unique case (state_reg)
            S_IDLE: begin
                if (grant_valid) begin
                    if (len_in[grant_port] == 8'd0) begin
                        state_next            = S_GAP;
                        done_next[grant_port] = 1'b1;
                        err_next[grant_port]  = 1'b1;
                    end else begin
                        state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // A completion arriving on the timeout cycle still counts as success.
                if (C_DONE) begin
                    state_next           = S_GAP;
                    done_next[owner_reg] = 1'b1;
                end else if (tmo_hit) begin
                    state_next           = S_GAP;
                    done_next[owner_reg] = 1'b1;
                    err_next[owner_reg]  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == 4'(GAP - 1)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        C_RD     = busy & ~wr_reg;
        C_WR     = busy & wr_reg;
        C_ADDR   = addr_reg;
        C_LENGTH = len_reg;
        C_DATAIN = '0;
        C_DM     = '0;
        // Data stays routed through GAP so a trailing write word is still delivered.
        if (state_reg != S_IDLE) begin
            C_DATAIN = wdata_in[owner_reg];
            C_DM     = dm_in[owner_reg];
        end
    end

    always_ff @(posedge REF_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_reg   <= 1'b0;
            last_reg    <= 1'b1;
            addr_reg    <= '0;
            len_reg     <= '0;
            wr_reg      <= 1'b0;
            gap_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            done_reg    <= 2'b00;
            err_reg     <= 2'b00;
        end else begin
            if (grant_valid) begin
                owner_reg <= grant_port;
                last_reg  <= grant_port;
                addr_reg  <= addr_in[grant_port];
                len_reg   <= len_in[grant_port];
                wr_reg    <= wr_in[grant_port];
            end
            gap_cnt_reg <= (state_reg == S_GAP) ? gap_cnt_reg + 4'd1 : 4'd0;
            tmo_cnt_reg <= busy ? tmo_cnt_reg + 12'd1 : 12'd0;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign in_req_out[gi]    = C_IN_REQ & busy & (owner_reg == 1'(gi));
            assign out_valid_out[gi] = C_OUT_VALID & busy & (owner_reg == 1'(gi));
        end
    endgenerate

    assign P0_IN_REQ    = in_req_out[0];
    assign P1_IN_REQ    = in_req_out[1];
    assign P0_OUT_VALID = out_valid_out[0];
    assign P1_OUT_VALID = out_valid_out[1];
    assign P0_RDATA     = C_DATAOUT;
    assign P1_RDATA     = C_DATAOUT;
    assign P0_DONE      = done_reg[0];
    assign P1_DONE      = done_reg[1];
    assign P0_ERR       = err_reg[0];
    assign P1_ERR       = err_reg[1];

endmodule

// File: doc/sdram_host_arbiter.md
# sdram_host_arbiter

Two-port arbiter that shares the single SDRAM controller host interface (ADDR/WR/RD/LENGTH/DONE/IN_REQ/OUT_VALID/DATAIN/DATAOUT/DM) between port 0 (instruction fetch) and port 1 (data load/store). It converts level-held per-port requests into the controller's rising-edge RD/WR protocol, grants round-robin, routes burst data to the owning port and enforces an idle gap so the controller re-arms. It sits between the cache/bus masters and `Sdram_Controller`, on the same clock.

## Interface
- ASIZE, 23, address width (matches controller `ASIZE`)
- DSIZE, 16, data width (matches controller `DSIZE`)
- GAP, 2, idle cycles with C_RD/C_WR low between transactions; legal 2..15
- TIMEOUT, 1023, max cycles from issue to C_DONE before abort; legal 16..4095

Ports:
- REF_CLK  in  1  clock; same clock as the controller
- RESET_N  in  1  asynchronous, active-low reset
- Pn_REQ  in  1  request, n=0,1; held high with fields stable until Pn_DONE
- Pn_WR  in  1  1=write burst, 0=read burst
- Pn_ADDR  in  ASIZE  start address
- Pn_LEN  in  8  burst length in words
- Pn_WDATA  in  DSIZE  write data, must be valid the cycle after Pn_IN_REQ
- Pn_DM  in  DSIZE/8  write byte mask
- Pn_IN_REQ  out  1  write-data request (gated C_IN_REQ)
- Pn_OUT_VALID  out  1  read data valid (gated C_OUT_VALID)
- Pn_RDATA  out  DSIZE  read data (C_DATAOUT broadcast to both ports)
- Pn_DONE  out  1  one-cycle completion pulse
- Pn_ERR  out  1  qualifies Pn_DONE: 1=aborted (timeout or LEN=0)
- C_ADDR, C_LENGTH  out  ASIZE, 8  to controller ADDR, LENGTH
- C_RD, C_WR  out  1  to controller RD, WR
- C_DATAIN, C_DM  out  DSIZE, DSIZE/8  to controller DATAIN, DM
- C_DONE, C_IN_REQ, C_OUT_VALID  in  1  from controller
- C_DATAOUT  in  DSIZE  from controller DATAOUT

## Operation
- States: IDLE, BUSY, GAP. Registers: owner (1b), last (1b), latched addr/len/wr, gap counter (4b), timeout counter (12b).
- IDLE: if no REQ, stay. One REQ -> grant it. Both REQ -> grant !last. On grant: owner=n, last=n, latch Pn_ADDR/LEN/WR.
- Grant with Pn_LEN=0: no command issued; next cycle Pn_DONE=1, Pn_ERR=1; go to GAP.
- BUSY: C_RD (wr=0) or C_WR (wr=1) held high; timeout counter increments. On C_DONE: drop C_RD/C_WR, pulse Pn_DONE (Pn_ERR=0), go to GAP. If counter reaches TIMEOUT first: drop C_RD/C_WR, pulse Pn_DONE with Pn_ERR=1, go to GAP.
- GAP: C_RD/C_WR low for GAP cycles, then IDLE. REQ ignored in GAP.
- A port keeping REQ high after its DONE is a new request; round-robin still applies.
- Routing: C_DATAIN/C_DM = owner's WDATA/DM (mux on registered owner). Pn_IN_REQ = C_IN_REQ & (owner==n) & BUSY; Pn_OUT_VALID likewise with C_OUT_VALID. Non-owner never sees IN_REQ/OUT_VALID.
- C_ADDR/C_LENGTH hold latched values from grant until next grant.

## Timing
- Reset values: state IDLE, owner=0, last=1 (port 0 wins first tie), all C_* and Pn_* outputs 0, counters 0.
- REQ sampled high in IDLE at edge t -> C_RD/C_WR and C_ADDR/C_LENGTH valid from t+1.
- C_DONE high at cycle d -> C_RD/C_WR low and Pn_DONE high at d+1 (one cycle only); IDLE at d+1+GAP; earliest next C_RD/C_WR at d+2+GAP.
- Pn_IN_REQ/Pn_OUT_VALID are combinational from C_*: zero added latency.
- Timeout: abort on cycle TIMEOUT after C_RD/C_WR rise.
- Reset mid-burst: all outputs zero immediately; controller is reset by the same RESET_N, so no recovery sequence.
- REQ dropped by a requester during BUSY: ignored; transaction completes and DONE still pulses.

## Test plan
- Single read: P0 REQ, ADDR=0x000100, LEN=8 -> C_RD=1 next cycle, 8 P0_OUT_VALID cycles, P0_DONE=1/P0_ERR=0 one cycle after C_DONE, C_RD low GAP=2 cycles.
- Single write: P1 WR, LEN=4, WDATA=0xA5A0+i, DM=2'b00 -> C_DATAIN tracks P1_WDATA, 4 P1_IN_REQ cycles, P0_IN_REQ stays 0.
- Tie after reset: P0 and P1 REQ same cycle -> P0 granted first, P1 granted next; repeat tie -> P0 then P1 alternate.
- LEN=0 on P0 -> C_RD/C_WR never rise, P0_DONE=1 with P0_ERR=1 one cycle after grant.
- Controller model never asserts C_DONE -> after 1023 cycles C_RD drops, P1_DONE=1/P1_ERR=1, arbiter returns to IDLE after GAP.
- RESET_N low during BUSY -> all outputs 0 same cycle; after release P0 REQ granted with standard latency.
